vx_fifo_credit_tx: RTL and testbench
====================================

VX_FIFO_CREDIT_TX -- requirements
Module: VX_fifo_credit_tx

Interface
REQ-001 SHALL have parameter DATAW, default 1, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entry count of the remote receive FIFO (1..255, any integer).
REQ-003 SHALL have parameter CREDITW, default $clog2(DEPTH+1), width of the credit counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port valid_in  input  1  upstream payload valid.
REQ-007 SHALL have port data_in  input  DATAW  upstream payload.
REQ-008 SHALL have port ready_in  output  1  upstream accept enable.
REQ-009 SHALL have port push  output  1  write strobe to remote FIFO.
REQ-010 SHALL have port data_out  output  DATAW  payload to remote FIFO, valid when push=1.
REQ-011 SHALL have port credit_ret  input  1  one pulse per entry popped at the remote FIFO.
REQ-012 SHALL have port credits  output  CREDITW  current free remote entries.
REQ-013 SHALL have port idle  output  1  no entries in flight (credits==DEPTH and push==0).
REQ-014 SHALL have port ovf_err  output  1  sticky credit-overflow error.
REQ-015 SHALL have port perf_stalls  output  32  stall cycle count (see Configuration).

Function
REQ-016 SHALL define accept = valid_in & ready_in; ready_in SHALL be combinational: credits != 0.
REQ-017 SHALL register push <= accept, asserting push exactly one cycle after accept (latency 1); data_out SHALL load data_in on accept and hold otherwise.
REQ-018 SHALL sustain one accept per cycle while credits > 0 after update.
REQ-019 SHALL update credits <= credits - accept + credit_ret in CREDITW-bit arithmetic, evaluated in the accept cycle (not the push cycle).
REQ-020 SHALL treat accept and credit_ret in the same cycle as net zero, including at credits==0 (ready_in=0, so no accept) and credits==DEPTH.
REQ-021 SHALL make a credit returned in cycle N visible on ready_in in cycle N+1 (no combinational bypass).
REQ-022 SHALL, when credit_ret=1, accept=0 and credits==DEPTH, leave credits at DEPTH (saturate) and set ovf_err=1.
REQ-023 SHALL keep ovf_err at 1 until reset; no other event clears it.
REQ-024 SHALL never assert push when credits was 0 in the preceding cycle; a bench assertion SHALL check credits never exceeds DEPTH.
REQ-025 SHALL drive idle = (credits==DEPTH) & ~push, combinationally from registers.

Reset
REQ-026 SHALL, while reset==0 at a rising edge, set credits=DEPTH, push=0, data_out=0, ovf_err=0, perf_stalls=0.
REQ-027 SHALL, on reset asserted mid-transfer, discard any pending push (push=0 next cycle) and ignore credit_ret during reset; remote FIFO is reset in the same domain.
REQ-028 SHALL present ready_in=1 in the first cycle after reset release (DEPTH>=1).

Configuration
REQ-029 SHALL use macro VX_FIFO_CREDIT_TX_PERF_EN: when defined, perf_stalls increments by 1 (wrapping at 2^32) every cycle with valid_in=1 and ready_in=0.
REQ-030 SHALL, when VX_FIFO_CREDIT_TX_PERF_EN is undefined, tie perf_stalls to 0 and synthesize no counter logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: DEPTH=4, reset, valid_in=1 continuous, no credit_ret -> 4 accepts, push high cycles 1-4, credits 4,3,2,1,0, ready_in=0 from cycle 4.
REQ-032 SHALL cover: credits=0, credit_ret pulse at cycle N -> credits=1 and ready_in=1 at N+1, one push at N+2, credits back to 0.
REQ-033 SHALL cover: credits=2, accept and credit_ret same cycle -> credits stays 2, push=1 next cycle with data_out=data_in.
REQ-034 SHALL cover: credits=4, idle=1, credit_ret=1 -> credits stays 4, ovf_err=1, remains 1 after 100 idle cycles.
REQ-035 SHALL cover: PERF_EN defined, credits=0, valid_in=1 for 10 cycles -> perf_stalls=10; undefined -> perf_stalls=0.
REQ-036 SHALL cover: reset asserted in cycle after accept with credits=1 -> push=0, credits=4, ovf_err=0 following cycle.

Source files
------------

// File: rtl/vx_fifo_credit_tx.sv
// Credit-based transmitter: forwards payloads to a remote FIFO only while it holds free-entry credits.
// Optional stall counter enabled by defining VX_FIFO_CREDIT_TX_PERF_EN.
module vx_fifo_credit_tx #(
  parameter int DATAW   = 1,
  parameter int DEPTH   = 4,
  parameter int CREDITW = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [DATAW-1:0]   data_in,
  output logic               ready_in,
  output logic               push,
  output logic [DATAW-1:0]   data_out,
  input  logic               credit_ret,
  output logic [CREDITW-1:0] credits,
  output logic               idle,
  output logic               ovf_err,
  output logic [31:0]        perf_stalls
);

  localparam logic [CREDITW-1:0] DEPTH_C = CREDITW'(DEPTH);
  localparam logic [CREDITW-1:0] ONE_C   = CREDITW'(1);

  logic [CREDITW-1:0] credits_reg, credits_next;
  logic               push_reg;
  logic [DATAW-1:0]   data_reg;
  logic               ovf_reg, ovf_next;
  logic               accept;

  // ready depends only on registered credits, so a returned credit shows up one cycle later
  assign ready_in = (credits_reg != '0);
  assign accept   = valid_in & ready_in;

  always_comb begin
    credits_next = credits_reg;
    ovf_next     = ovf_reg;
    if (accept && !credit_ret) begin
      credits_next = credits_reg - ONE_C;
    end else if (!accept && credit_ret) begin
      // A return with nothing outstanding is a protocol error: saturate and flag it
      if (credits_reg == DEPTH_C) begin
        ovf_next = 1'b1;
      end else begin
        credits_next = credits_reg + ONE_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      credits_reg <= DEPTH_C;
      push_reg    <= 1'b0;
      data_reg    <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      credits_reg <= credits_next;
      push_reg    <= accept;
      ovf_reg     <= ovf_next;
      if (accept) begin
        data_reg <= data_in;
      end
    end
  end

  assign credits  = credits_reg;
  assign push     = push_reg;
  assign data_out = data_reg;
  assign ovf_err  = ovf_reg;
  assign idle     = (credits_reg == DEPTH_C) & ~push_reg;

`ifdef VX_FIFO_CREDIT_TX_PERF_EN
  logic [31:0] perf_stalls_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stalls_reg <= '0;
    end else if (valid_in && !ready_in) begin
      perf_stalls_reg <= perf_stalls_reg + 32'd1;
    end
  end

  assign perf_stalls = perf_stalls_reg;
`else
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_vx_fifo_credit_tx.sv
// Self-checking bench for vx_fifo_credit_tx: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic credit model.
module tb_vx_fifo_credit_tx;

  localparam int DATAW   = 8;
  localparam int DEPTH   = 4;
  localparam int CREDITW = $clog2(DEPTH+1);
`ifdef VX_FIFO_CREDIT_TX_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               valid_in = 1'b0;
  logic [DATAW-1:0]   data_in = '0;
  logic               credit_ret = 1'b0;
  logic               ready_in;
  logic               push;
  logic [DATAW-1:0]   data_out;
  logic [CREDITW-1:0] credits;
  logic               idle;
  logic               ovf_err;
  logic [31:0]        perf_stalls;

  vx_fifo_credit_tx #(.DATAW(DATAW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .push(push), .data_out(data_out),
    .credit_ret(credit_ret), .credits(credits), .idle(idle),
    .ovf_err(ovf_err), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: free entries = DEPTH minus entries in flight, clamped at DEPTH
  int          m_credits = DEPTH;
  int          m_push = 0;
  int          m_data = 0;
  int          m_ovf = 0;
  bit [31:0]   m_stalls = 0;
  bit          model_ok = 0;

  always @(posedge clk) begin
    int acc;
    int n;
    if (!reset) begin
      m_credits = DEPTH; m_push = 0; m_data = 0; m_ovf = 0; m_stalls = 0;
      model_ok = 1;
    end else begin
      acc = (valid_in && m_credits > 0) ? 1 : 0;
      if (PERF_ON != 0 && valid_in && m_credits == 0) m_stalls = m_stalls + 1;
      if (acc != 0) m_data = int'(data_in);
      m_push = acc;
      n = m_credits - acc + (credit_ret ? 1 : 0);
      if (n > DEPTH) begin
        n = DEPTH;
        m_ovf = 1;
      end
      m_credits = n;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("ready_in", 32'(ready_in), 32'(m_credits != 0));
      check("push", 32'(push), 32'(m_push));
      check("data_out", 32'(data_out), 32'(m_data));
      check("credits", 32'(credits), 32'(m_credits));
      check("idle", 32'(idle), 32'(m_credits == DEPTH && m_push == 0));
      check("ovf_err", 32'(ovf_err), 32'(m_ovf));
      check("perf_stalls", perf_stalls, m_stalls);
      checks++;
      if (int'(credits) > DEPTH) begin
        errors++;
        $display("FAIL credits_bound: got %0d limit %0d", credits, DEPTH);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Fill from empty with continuous valid and no returns
    check("rst_credits", 32'(credits), 32'd4);
    check("rst_ready", 32'(ready_in), 32'd1);
    check("rst_push", 32'(push), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    reset = 1'b1;
    valid_in = 1'b1;
    data_in = 8'h11;
    check("rel_ready", 32'(ready_in), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      data_in = 8'(8'h11 + i);
      check("fill_push", 32'(push), 32'd1);
      check("fill_credits", 32'(credits), 32'(4 - i));
    end
    check("fill_ready0", 32'(ready_in), 32'd0);
    tick();
    check("fill_nopush", 32'(push), 32'd0);
    check("fill_cred0", 32'(credits), 32'd0);

    // Single credit return while starved
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    check("ret_credits", 32'(credits), 32'd1);
    check("ret_ready", 32'(ready_in), 32'd1);
    check("ret_nopush", 32'(push), 32'd0);
    tick();
    check("ret_push", 32'(push), 32'd1);
    check("ret_cred0", 32'(credits), 32'd0);
    valid_in = 1'b0;

    // Accept and return in the same cycle at credits==2
    credit_ret = 1'b1;
    tick();
    tick();
    check("net_pre", 32'(credits), 32'd2);
    valid_in = 1'b1;
    data_in = 8'hA5;
    tick();
    valid_in = 1'b0;
    credit_ret = 1'b0;
    check("net_credits", 32'(credits), 32'd2);
    check("net_push", 32'(push), 32'd1);
    check("net_data", 32'(data_out), 32'hA5);

    // Overflow at full credit, sticky across idle cycles
    credit_ret = 1'b1;
    tick();
    tick();
    credit_ret = 1'b0;
    check("full_credits", 32'(credits), 32'd4);
    check("full_idle", 32'(idle), 32'd1);
    check("full_ovf0", 32'(ovf_err), 32'd0);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    check("ovf_credits", 32'(credits), 32'd4);
    check("ovf_set", 32'(ovf_err), 32'd1);
    repeat (100) tick();
    check("ovf_sticky", 32'(ovf_err), 32'd1);

    // Stall counting: 4 accepts then 10 starved cycles
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("ovf_clr", 32'(ovf_err), 32'd0);
    valid_in = 1'b1;
    repeat (14) tick();
    valid_in = 1'b0;
    check("stalls", perf_stalls, (PERF_ON != 0) ? 32'd10 : 32'd0);

    // Reset the cycle after an accept that consumed the last credit
    reset = 1'b0;
    tick();
    reset = 1'b1;
    valid_in = 1'b1;
    repeat (3) tick();
    check("pre_last", 32'(credits), 32'd1);
    tick();
    check("last_push", 32'(push), 32'd1);
    reset = 1'b0;
    valid_in = 1'b0;
    credit_ret = 1'b1;
    tick();
    reset = 1'b1;
    credit_ret = 1'b0;
    check("mid_rst_push", 32'(push), 32'd0);
    check("mid_rst_cred", 32'(credits), 32'd4);
    check("mid_rst_ovf", 32'(ovf_err), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 150) != 0;
      valid_in = ($urandom % 4) != 0;
      credit_ret = ($urandom % 3) == 0;
      data_in = 8'($urandom);
      tick();
    end
    valid_in = 1'b0;
    credit_ret = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
